// File: rtl/data_cache_controller_pkg.sv
// Shared constants and helpers for the direct-mapped write-through L1 data cache.
package data_cache_controller_pkg;

    localparam int LINE_WORDS     = 8;
    localparam int OFFSET_WIDTH   = 5;
    localparam int WORD_SEL_WIDTH = 3;
    localparam int LINE_BITS      = LINE_WORDS * 32;

    localparam logic [1:0] CACHE_IDLE        = 2'd0;
    localparam logic [1:0] CACHE_REFILL_REQ  = 2'd1;
    localparam logic [1:0] CACHE_REFILL_FILL = 2'd2;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_cache_controller_line_store.sv
// Valid/tag/data arrays for the data cache: combinational read, line fill and masked word write.
module dcache_line_store
    import data_cache_controller_pkg::*;
#(
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 32 - OFFSET_WIDTH - INDEX_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      invalidate,
    input  logic [INDEX_WIDTH-1:0]    rd_index,
    output logic                      rd_valid,
    output logic [TAG_WIDTH-1:0]      rd_tag,
    output logic [LINE_BITS-1:0]      rd_line,
    input  logic                      fill_en,
    input  logic [INDEX_WIDTH-1:0]    fill_index,
    input  logic [TAG_WIDTH-1:0]      fill_tag,
    input  logic [LINE_BITS-1:0]      fill_line,
    input  logic                      wr_en,
    input  logic [INDEX_WIDTH-1:0]    wr_index,
    input  logic [WORD_SEL_WIDTH-1:0] wr_word,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_mask
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [TAG_WIDTH-1:0] tag_d  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];
    logic [LINE_BITS-1:0] data_d [LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[fill_index] = 1'b1;
            tag_d[fill_index]   = fill_tag;
            data_d[fill_index]  = fill_line;
        end else if (wr_en) begin
            data_d[wr_index][{wr_word, 5'd0} +: 32] =
                merge_bytes(data_q[wr_index][{wr_word, 5'd0} +: 32], wr_data, wr_mask);
        end
        // Invalidate wins over a same-edge fill so a fenced line never survives.
        if (invalidate) valid_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) valid_q <= '0;
        else          valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller (FSM + output muxing).
module data_cache_controller
    import data_cache_controller_pkg::*;
#(
    parameter int INDEX_WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cpu_read,
    input  logic           cpu_write,
    input  logic [31:0]    cpu_address,
    input  logic [31:0]    cpu_write_data,
    input  logic [3:0]     cpu_write_mask,
    input  logic           cache_invalidate,
    output logic [31:0]    cpu_read_data,
    output logic           cpu_ready,
    output logic           mem_write_enable,
    output logic [31:0]    mem_address,
    output logic [31:0]    mem_write_data,
    output logic [3:0]     mem_write_mask,
    input  logic [255:0]   mem_read_data
);

    localparam int TAG_WIDTH = 32 - OFFSET_WIDTH - INDEX_WIDTH;

    logic [1:0]                state_q, state_d;
    logic [INDEX_WIDTH-1:0]    fill_index_q, fill_index_d;
    logic [TAG_WIDTH-1:0]      fill_tag_q, fill_tag_d;

    logic [INDEX_WIDTH-1:0]    req_index;
    logic [TAG_WIDTH-1:0]      req_tag;
    logic [WORD_SEL_WIDTH-1:0] req_word;
    logic                      rd_valid;
    logic [TAG_WIDTH-1:0]      rd_tag;
    logic [LINE_BITS-1:0]      rd_line;
    logic                      hit;
    logic                      fill_en;
    logic                      wr_en;

    assign req_index = cpu_address[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_tag   = cpu_address[31 -: TAG_WIDTH];
    assign req_word  = cpu_address[4:2];
    assign hit       = (state_q == CACHE_IDLE) && rd_valid && (rd_tag == req_tag);

    dcache_line_store #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_store (
        .clk        (clk),
        .reset_n    (reset_n),
        .invalidate (cache_invalidate),
        .rd_index   (req_index),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .fill_en    (fill_en),
        .fill_index (fill_index_q),
        .fill_tag   (fill_tag_q),
        .fill_line  (mem_read_data),
        .wr_en      (wr_en),
        .wr_index   (req_index),
        .wr_word    (req_word),
        .wr_data    (cpu_write_data),
        .wr_mask    (cpu_write_mask)
    );

    always_comb begin
        state_d          = state_q;
        fill_index_d     = fill_index_q;
        fill_tag_d       = fill_tag_q;
        fill_en          = 1'b0;
        wr_en            = 1'b0;
        cpu_ready        = 1'b0;
        cpu_read_data    = '0;
        mem_write_enable = 1'b0;
        mem_address      = cpu_address;
        mem_write_data   = cpu_write_data;
        mem_write_mask   = '0;
        case (state_q)
            CACHE_IDLE: begin
                if (cpu_write) begin
                    mem_write_enable = 1'b1;
                    mem_write_mask   = cpu_write_mask;
                    cpu_ready        = 1'b1;
                    wr_en            = hit;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_ready     = 1'b1;
                        cpu_read_data = rd_line[{req_word, 5'd0} +: 32];
                    end else begin
                        mem_address  = {req_tag, req_index, 5'd0};
                        fill_index_d = req_index;
                        fill_tag_d   = req_tag;
                        state_d      = CACHE_REFILL_REQ;
                    end
                end
            end
            CACHE_REFILL_REQ: begin
                mem_address = {fill_tag_q, fill_index_q, 5'd0};
                state_d     = cache_invalidate ? CACHE_IDLE : CACHE_REFILL_FILL;
            end
            CACHE_REFILL_FILL: begin
                mem_address = {fill_tag_q, fill_index_q, 5'd0};
                fill_en     = !cache_invalidate;
                state_d     = CACHE_IDLE;
            end
            default: state_d = CACHE_IDLE;
        endcase
        // Outputs are forced quiet while reset is held, even if the core drives a request.
        if (!reset_n) begin
            fill_en          = 1'b0;
            wr_en            = 1'b0;
            cpu_ready        = 1'b0;
            cpu_read_data    = '0;
            mem_write_enable = 1'b0;
            mem_address      = '0;
            mem_write_data   = '0;
            mem_write_mask   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CACHE_IDLE;
            fill_index_q <= '0;
            fill_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            fill_index_q <= fill_index_d;
            fill_tag_q   <= fill_tag_d;
        end
    end

endmodule

// File: tb/tb_data_cache_controller.sv
// Randomized scoreboard bench for data_cache_controller with a line-residency reference model.
module tb_data_cache_controller;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cpu_read = 1'b0, cpu_write = 1'b0, cache_invalidate = 1'b0;
    logic [31:0]  cpu_address = '0, cpu_write_data = '0;
    logic [3:0]   cpu_write_mask = '0;
    logic [31:0]  cpu_read_data, mem_address, mem_write_data;
    logic         cpu_ready, mem_write_enable;
    logic [3:0]   mem_write_mask;
    logic [255:0] mem_read_data = '0;

    data_cache_controller #(.INDEX_WIDTH(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cpu_read         (cpu_read),
        .cpu_write        (cpu_write),
        .cpu_address      (cpu_address),
        .cpu_write_data   (cpu_write_data),
        .cpu_write_mask   (cpu_write_mask),
        .cache_invalidate (cache_invalidate),
        .cpu_read_data    (cpu_read_data),
        .cpu_ready        (cpu_ready),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_mask   (mem_write_mask),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] waddr);
        return (waddr * 32'h9E3779B1) ^ 32'h1357_2468;
    endfunction

    // Memory seen by the DUT: registered line read, single-word masked write.
    logic [31:0] mem_arr [int unsigned];
    function automatic logic [31:0] mem_rd(input logic [31:0] waddr);
        return mem_arr.exists(waddr) ? mem_arr[waddr] : init_word(waddr);
    endfunction

    always @(posedge clk) begin
        logic [255:0] line;
        for (int k = 0; k < 8; k++) line[32*k +: 32] = mem_rd({5'd0, mem_address[31:5], 3'(k)});
        if (mem_write_enable)
            mem_arr[mem_address >> 2] = merge(mem_rd(mem_address >> 2), mem_write_data, mem_write_mask);
        mem_read_data <= line;
    end

    // Reference model: flat memory image plus which line address each index holds.
    logic [31:0] ref_mem [int unsigned];
    bit          res_valid [16];
    logic [31:0] res_line  [16];

    function automatic logic [31:0] ref_rd(input logic [31:0] waddr);
        return ref_mem.exists(waddr) ? ref_mem[waddr] : init_word(waddr);
    endfunction

    function automatic void clear_res();
        for (int i = 0; i < 16; i++) res_valid[i] = 1'b0;
    endfunction

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] line;
        logic [3:0]  mask;
        int          stalls;
    } exp_t;
    exp_t sbq[$];
    bit   sb_on = 1'b0;
    int   stall_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (sb_on && reset_n && (cpu_read || cpu_write)) begin
            if (sbq.size() == 0) begin
                errs++; checks++;
                $display("FAIL sb_empty: request with no expectation at %0t", $time);
            end else begin
                e = sbq[0];
                if (!cpu_ready) begin
                    stall_cnt++;
                    if (e.rd) begin
                        chk("miss_mem_addr", mem_address, e.line);
                        chk("miss_no_wr", {31'd0, mem_write_enable}, 32'd0);
                    end else begin
                        chk("wr_ready", {31'd0, cpu_ready}, 32'd1);
                    end
                end else begin
                    void'(sbq.pop_front());
                    chk("stalls", stall_cnt, e.stalls);
                    if (e.rd) begin
                        chk("rd_data", cpu_read_data, e.data);
                        chk("rd_no_wr", {31'd0, mem_write_enable}, 32'd0);
                    end else begin
                        chk("wr_en", {31'd0, mem_write_enable}, 32'd1);
                        chk("wr_addr", mem_address, e.addr);
                        chk("wr_data", mem_write_data, e.data);
                        chk("wr_mask", {28'd0, mem_write_mask}, {28'd0, e.mask});
                    end
                    stall_cnt = 0;
                end
            end
        end else begin
            stall_cnt = 0;
        end
    end

    // inv_cyc: cycle (relative to request start) carrying the invalidate pulse, -1 for none.
    task automatic do_req(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input int inv_cyc);
        exp_t e;
        int   idx;
        bit   hit, done;
        idx      = int'(addr[8:5]);
        hit      = res_valid[idx] && (res_line[idx] == {addr[31:5], 5'd0});
        e.rd     = !is_wr;
        e.addr   = addr;
        e.line   = {addr[31:5], 5'd0};
        e.mask   = mask;
        e.data   = is_wr ? wdata : ref_rd(addr >> 2);
        e.stalls = (is_wr || hit) ? 0 : (inv_cyc == 2 ? 6 : 3);
        if (is_wr) ref_mem[addr >> 2] = merge(ref_rd(addr >> 2), wdata, mask);
        if (inv_cyc >= 0) clear_res();
        if (!is_wr && !hit) begin
            res_valid[idx] = 1'b1;
            res_line[idx]  = e.line;
        end
        sbq.push_back(e);

        cpu_read = !is_wr; cpu_write = is_wr; cpu_address = addr;
        cpu_write_data = wdata; cpu_write_mask = mask;
        cache_invalidate = (inv_cyc == 0);
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cpu_ready) begin done = 1'b1; break; end
            @(posedge clk); #1;
            cache_invalidate = (c + 1 == inv_cyc);
        end
        if (!done) begin
            errs++; checks++;
            $display("FAIL timeout: no cpu_ready for addr %h", addr);
            sbq.delete();
        end
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0; cache_invalidate = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, {31'd0, cpu_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_write_enable}, 32'd0);
        chk({tag, "_mask"}, {28'd0, mem_write_mask}, 32'd0);
        chk({tag, "_rdata"}, cpu_read_data, 32'd0);
    endtask

    initial begin
        clear_res();
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        sb_on = 1'b1;

        do_req(1'b0, 32'h40, '0, '0, -1);               // miss, refill
        do_req(1'b0, 32'h5C, '0, '0, -1);               // hit, word 7
        do_req(1'b1, 32'h44, 32'hAABBCCDD, 4'b0010, -1); // write hit
        do_req(1'b0, 32'h44, '0, '0, -1);
        do_req(1'b1, 32'h1000, 32'h12345678, 4'b1111, -1); // write miss, no allocate
        do_req(1'b0, 32'h1000, '0, '0, -1);
        do_req(1'b0, 32'h240, '0, '0, -1);              // evicts 0x40
        do_req(1'b0, 32'h40, '0, '0, -1);
        do_req(1'b0, 32'h80, '0, '0, 2);                // invalidate during fill

        // Reset in the middle of a refill request.
        sb_on = 1'b0;
        cpu_read = 1'b1; cpu_address = 32'hA0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1 chk_quiet("midrst");
        chk("midrst_addr", mem_address, 32'd0);
        repeat (2) @(negedge clk);
        chk_quiet("midrst2");
        reset_n = 1'b1; cpu_read = 1'b0;
        clear_res();
        @(posedge clk); #1;
        sb_on = 1'b1;
        do_req(1'b0, 32'hA0, '0, '0, -1);
        do_req(1'b0, 32'h80, '0, '0, -1);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 99) < 5) a = a | 32'h0001_0000;
            do_req($urandom_range(0, 99) < 40, a, $urandom, 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 99) < 6) ? 0 : -1);
        end

        repeat (2) @(posedge clk);
        if (sbq.size() != 0) begin
            errs++; checks++;
            $display("FAIL sb_leftover: %0d expectations unconsumed", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
